// File: rtl/branch_resolve_bht.sv
// Decode-stage branch resolver with a PC-indexed table of 2-bit saturating
// counters. It resolves conditional branches, feeds the taken prediction to
// fetch, trains the table on each resolved branch, and keeps saturating
// branch and misprediction counters.
module branch_resolve_bht #(
  parameter int         WIDTH     = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] CNT_INIT  = 2'b01,
  parameter int         STAT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  pc_f,
  output logic              pred_taken_f,
  input  logic [31:0]       ir_d,
  input  logic [WIDTH-1:0]  v1_d,
  input  logic [WIDTH-1:0]  v2_d,
  input  logic [WIDTH-1:0]  pc_d,
  input  logic              pred_taken_d,
  input  logic              valid_d,
  input  logic              stall_d,
  output logic              is_branch_d,
  output logic              taken_d,
  output logic              mispredict_d,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_d;
  logic [5:0]       op;
  logic [4:0]       rt;
  logic signed [WIDTH-1:0] v1_s;
  logic             v1_neg;
  logic             v1_zero;
  logic             resolve;
  logic             unused;

  // Two-bit counter step toward the resolved direction, pinned at both ends.
  function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && cnt != 2'b11)
      nxt = cnt + 2'b01;
    else if (!taken && cnt != 2'b00)
      nxt = cnt - 2'b01;
    return nxt;
  endfunction

  // Statistics counters stop at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  assign idx_f = pc_f[IDX_W+1:2];
  assign idx_d = pc_d[IDX_W+1:2];
  assign op    = ir_d[31:26];
  assign rt    = ir_d[20:16];
  assign v1_s  = v1_d;

  // Sign and zero tests cover every signed compare against zero.
  assign v1_neg  = v1_s[WIDTH-1];
  assign v1_zero = (v1_s == '0);

  // Old entry value is returned on a same-index write: no bypass.
  assign pred_taken_f = bht[idx_f][1];

  // Branch decode and condition evaluation; every path assigns both outputs.
  always_comb begin
    is_branch_d = 1'b0;
    taken_d     = 1'b0;
    case (op)
      OP_BEQ: begin
        is_branch_d = 1'b1;
        taken_d     = (v1_d == v2_d);
      end
      OP_BNE: begin
        is_branch_d = 1'b1;
        taken_d     = (v1_d != v2_d);
      end
      OP_BLEZ: begin
        is_branch_d = 1'b1;
        taken_d     = v1_neg | v1_zero;
      end
      OP_BGTZ: begin
        is_branch_d = 1'b1;
        taken_d     = ~v1_neg & ~v1_zero;
      end
      OP_REGIMM: begin
        if (rt == RT_BLTZ) begin
          is_branch_d = 1'b1;
          taken_d     = v1_neg;
        end else if (rt == RT_BGEZ) begin
          is_branch_d = 1'b1;
          taken_d     = ~v1_neg;
        end
      end
      default: begin
        is_branch_d = 1'b0;
        taken_d     = 1'b0;
      end
    endcase
  end

  assign mispredict_d = valid_d & is_branch_d & ~stall_d & (taken_d != pred_taken_d);
  assign resolve      = valid_d & is_branch_d & ~stall_d & reset;

  // BHT: reset to the initial bias, otherwise train the entry on each resolve.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < BHT_DEPTH; i++)
        bht[i] <= CNT_INIT;
    end else if (resolve) begin
      bht[idx_d] <= bht_next(bht[idx_d], taken_d);
    end
  end

  // Resolved-branch and misprediction statistics.
  always_ff @(posedge clk) begin
    if (!reset) begin
      br_count   <= '0;
      miss_count <= '0;
    end else if (resolve) begin
      br_count <= stat_inc(br_count);
      if (mispredict_d)
        miss_count <= stat_inc(miss_count);
    end
  end

  assign unused = ^{pc_f[1:0], pc_f[WIDTH-1:IDX_W+2], pc_d[1:0], pc_d[WIDTH-1:IDX_W+2],
                    ir_d[25:21], ir_d[15:0]};

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Self-checking bench for branch_resolve_bht: a full-width instance and a
// 2-bit-statistics instance share all inputs; a behavioural model tracks the
// table and counters and is compared every cycle, alongside directed checks.
module tb_branch_resolve_bht;

  localparam logic [31:0] IR_BEQ  = 32'h1000_0000;
  localparam logic [31:0] IR_BNE  = 32'h1400_0000;
  localparam logic [31:0] IR_BLEZ = 32'h1800_0000;
  localparam logic [31:0] IR_BGTZ = 32'h1C00_0000;
  localparam logic [31:0] IR_BLTZ = 32'h0400_0000;
  localparam logic [31:0] IR_BGEZ = 32'h0401_0000;
  localparam logic [31:0] IR_RIM2 = 32'h0402_0000;
  localparam logic [31:0] IR_ADDU = 32'h0022_1821;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_f, ir_d, v1_d, v2_d, pc_d;
  logic        pred_taken_d, valid_d, stall_d;

  logic        pred_taken_f, is_branch_d, taken_d, mispredict_d;
  logic [31:0] br_count, miss_count;
  logic        s_pred_taken_f, s_is_branch_d, s_taken_d, s_mispredict_d;
  logic [1:0]  s_br_count, s_miss_count;

  int tests = 0;
  int fails = 0;

  // model state
  logic [1:0]  m_bht [64];
  logic [31:0] m_br, m_miss;
  int          m_br2, m_miss2;
  bit          mon_on = 1'b0;

  always #5 clk = ~clk;

  branch_resolve_bht #(.WIDTH(32), .BHT_DEPTH(64), .CNT_INIT(2'b01), .STAT_W(32)) u_dut (
    .clk(clk), .reset(reset), .pc_f(pc_f), .pred_taken_f(pred_taken_f),
    .ir_d(ir_d), .v1_d(v1_d), .v2_d(v2_d), .pc_d(pc_d),
    .pred_taken_d(pred_taken_d), .valid_d(valid_d), .stall_d(stall_d),
    .is_branch_d(is_branch_d), .taken_d(taken_d), .mispredict_d(mispredict_d),
    .br_count(br_count), .miss_count(miss_count));

  branch_resolve_bht #(.WIDTH(32), .BHT_DEPTH(64), .CNT_INIT(2'b01), .STAT_W(2)) u_sat (
    .clk(clk), .reset(reset), .pc_f(pc_f), .pred_taken_f(s_pred_taken_f),
    .ir_d(ir_d), .v1_d(v1_d), .v2_d(v2_d), .pc_d(pc_d),
    .pred_taken_d(pred_taken_d), .valid_d(valid_d), .stall_d(stall_d),
    .is_branch_d(s_is_branch_d), .taken_d(s_taken_d), .mispredict_d(s_mispredict_d),
    .br_count(s_br_count), .miss_count(s_miss_count));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {is_branch, taken} straight from the instruction-set rules.
  function automatic logic [1:0] m_dec(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b);
    int sa;
    sa = a;
    case (ir[31:26])
      6'd4: return {1'b1, a == b};
      6'd5: return {1'b1, a != b};
      6'd6: return {1'b1, sa <= 0};
      6'd7: return {1'b1, sa > 0};
      6'd1: begin
        if (ir[20:16] == 5'd0) return {1'b1, sa < 0};
        if (ir[20:16] == 5'd1) return {1'b1, sa >= 0};
        return 2'b00;
      end
      default: return 2'b00;
    endcase
  endfunction

  // Model update at each rising edge from the inputs present at that edge.
  always @(posedge clk) begin
    logic [1:0] d;
    int         e;
    bit         miss;
    if (!reset) begin
      for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
      m_br = 0; m_miss = 0; m_br2 = 0; m_miss2 = 0;
      mon_on = 1'b1;
    end else begin
      d = m_dec(ir_d, v1_d, v2_d);
      if (valid_d && d[1] && !stall_d) begin
        e = int'(pc_d[7:2]);
        if (d[0] && m_bht[e] < 2'd3) m_bht[e] = m_bht[e] + 2'd1;
        else if (!d[0] && m_bht[e] > 2'd0) m_bht[e] = m_bht[e] - 2'd1;
        miss = (d[0] != pred_taken_d);
        if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
        if (m_br2 < 3) m_br2++;
        if (miss) begin
          if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
          if (m_miss2 < 3) m_miss2++;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [1:0] d;
    logic       mp;
    if (mon_on) begin
      d  = m_dec(ir_d, v1_d, v2_d);
      mp = valid_d & d[1] & ~stall_d & (d[0] != pred_taken_d);
      check("mon_is_branch", {31'b0, is_branch_d}, {31'b0, d[1]});
      check("mon_taken", {31'b0, taken_d}, {31'b0, d[0]});
      check("mon_mispredict", {31'b0, mispredict_d}, {31'b0, mp});
      check("mon_pred_f", {31'b0, pred_taken_f}, {31'b0, m_bht[pc_f[7:2]][1]});
      check("mon_br_count", br_count, m_br);
      check("mon_miss_count", miss_count, m_miss);
      check("mon_sat_pred_f", {31'b0, s_pred_taken_f}, {31'b0, m_bht[pc_f[7:2]][1]});
      check("mon_sat_br", {30'b0, s_br_count}, m_br2);
      check("mon_sat_miss", {30'b0, s_miss_count}, m_miss2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; pc_f = 32'h3000; ir_d = 32'h0; v1_d = 0; v2_d = 0; pc_d = 0;
    pred_taken_d = 1'b0; valid_d = 1'b0; stall_d = 1'b0;

    // reset
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_br_count", br_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    check("rst_pred_3000", {31'b0, pred_taken_f}, 32'd0);
    pc_f = 32'h30FC;
    #1 check("rst_pred_30FC", {31'b0, pred_taken_f}, 32'd0);

    // BEQ training at 0x3004
    step();
    pc_f = 32'h3004; pc_d = 32'h3004; ir_d = IR_BEQ; v1_d = 5; v2_d = 5;
    pred_taken_d = 1'b0; valid_d = 1'b1;
    #1;
    check("beq_taken_c1", {31'b0, taken_d}, 32'd1);
    check("beq_mispredict_c1", {31'b0, mispredict_d}, 32'd1);
    check("beq_pred_f_old", {31'b0, pred_taken_f}, 32'd0);
    step();
    check("beq_pred_f_after1", {31'b0, pred_taken_f}, 32'd1);
    step();
    pred_taken_d = 1'b1;
    #1 check("beq_mispredict_c3", {31'b0, mispredict_d}, 32'd0);
    step();
    valid_d = 1'b0;
    #1;
    check("beq_br_count", br_count, 32'd3);
    check("beq_miss_count", miss_count, 32'd2);
    check("beq_pred_f_sat", {31'b0, pred_taken_f}, 32'd1);

    // signed edges, decode only
    step(); ir_d = IR_BLEZ; v1_d = 32'h8000_0000;
    #1 check("blez_min_taken", {31'b0, taken_d}, 32'd1);
    step(); ir_d = IR_BGTZ; v1_d = 32'h0;
    #1 check("bgtz_zero_taken", {31'b0, taken_d}, 32'd0);
    check("bgtz_is_branch", {31'b0, is_branch_d}, 32'd1);
    step(); ir_d = IR_BGEZ; v1_d = 32'h0;
    #1 check("bgez_zero_taken", {31'b0, taken_d}, 32'd1);
    step(); ir_d = IR_BLTZ; v1_d = 32'h7FFF_FFFF;
    #1 check("bltz_max_taken", {31'b0, taken_d}, 32'd0);

    // stalled BNE resolves once, on release
    step();
    ir_d = IR_BNE; v1_d = 1; v2_d = 2; pred_taken_d = 1'b0;
    pc_d = 32'h3010; pc_f = 32'h3010; valid_d = 1'b1; stall_d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("stall_mispredict", {31'b0, mispredict_d}, 32'd0);
      step();
    end
    check("stall_br_hold", br_count, 32'd3);
    check("stall_pred_hold", {31'b0, pred_taken_f}, 32'd0);
    stall_d = 1'b0;
    #1 check("release_mispredict", {31'b0, mispredict_d}, 32'd1);
    step();
    valid_d = 1'b0;
    #1;
    check("release_br_count", br_count, 32'd4);
    check("release_miss_count", miss_count, 32'd3);
    check("release_pred_f", {31'b0, pred_taken_f}, 32'd1);
    step(); step();
    check("bubble_br_count", br_count, 32'd4);

    // non-branches
    valid_d = 1'b1; ir_d = IR_RIM2;
    #1;
    check("rim2_is_branch", {31'b0, is_branch_d}, 32'd0);
    check("rim2_taken", {31'b0, taken_d}, 32'd0);
    step();
    ir_d = IR_ADDU;
    #1;
    check("addu_is_branch", {31'b0, is_branch_d}, 32'd0);
    check("addu_taken", {31'b0, taken_d}, 32'd0);
    step();
    valid_d = 1'b0;
    #1;
    check("nonbr_br_count", br_count, 32'd4);
    check("nonbr_miss_count", miss_count, 32'd3);

    // saturation of 2-bit statistics, then reset colliding with a resolve
    ir_d = IR_BEQ; v1_d = 7; v2_d = 7; pred_taken_d = 1'b0;
    pc_d = 32'h3020; pc_f = 32'h3020; valid_d = 1'b1;
    repeat (5) step();
    valid_d = 1'b0;
    #1;
    check("sat_br_count", {30'b0, s_br_count}, 32'd3);
    check("sat_miss_count", {30'b0, s_miss_count}, 32'd3);
    check("wide_br_count", br_count, 32'd9);
    check("wide_miss_count", miss_count, 32'd8);
    check("trained_pred_3020", {31'b0, pred_taken_f}, 32'd1);
    step();
    valid_d = 1'b1; reset = 1'b0;
    #1 check("rst_mispredict_comb", {31'b0, mispredict_d}, 32'd1);
    step();
    reset = 1'b1; valid_d = 1'b0;
    #1;
    check("rstcol_br", br_count, 32'd0);
    check("rstcol_miss", miss_count, 32'd0);
    check("rstcol_sat_br", {30'b0, s_br_count}, 32'd0);
    check("rstcol_sat_miss", {30'b0, s_miss_count}, 32'd0);
    check("rstcol_pred_3020", {31'b0, pred_taken_f}, 32'd0);
    pc_f = 32'h3004;
    #1 check("rstcol_pred_3004", {31'b0, pred_taken_f}, 32'd0);

    // first resolve after reset
    step();
    valid_d = 1'b1;
    step();
    valid_d = 1'b0;
    #1;
    check("post_rst_br", br_count, 32'd1);
    check("post_rst_miss", miss_count, 32'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
